// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit/receive blocks.
// Holds the receiver state encoding and the common framing constants.
package serial_pkg;

    localparam int DATA_BITS        = 8;
    localparam int DEFAULT_BAUD_DIV = 5209;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/serial_sync.sv
// Multi-flop synchronizer for an asynchronous level input.
// Flops preset to 1 so an idle-high line stays idle through reset.
module serial_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/serialrx.sv
// 8N1 UART receiver: centre-sampled frames, held data byte, valid/ack handshake.
// Handshake: rx_valid stays high until a cycle with rx_ack=1 and rx_valid=1.
module serialrx
    import serial_pkg::*;
#(
    parameter int BAUD_DIV    = DEFAULT_BAUD_DIV,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rx_s;
    logic                 rx_prev;
    rx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;

    serial_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            rx_prev   <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_prev   <= rx_s;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
            end
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_s) begin
                        state <= RX_START;
                        busy  <= 1'b1;
                    end
                end
                RX_START: begin
                    // Half-bit check rejects glitches shorter than half a bit.
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= RX_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == LAST_BIT) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt  <= '0;
                        data <= shift;
                        if (rx_s) begin
                            // A same-cycle ack consumes the old byte, so no overrun.
                            rx_valid <= 1'b1;
                            overrun  <= rx_valid && !rx_ack;
                            state    <= RX_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= RX_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serialrx.sv
// Bench for serialrx at BAUD_DIV=16: frame table, corner sequences,
// randomized frames against a frame-level model, and a loopback stream.
module tb_serialrx;

    localparam int BAUD = 16;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1 + BAUD / 2 + 9 * BAUD;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       rx_valid;
    logic       rx_ack;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    serialrx #(.BAUD_DIV(BAUD), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .rx_valid  (rx_valid),
        .rx_ack    (rx_ack),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    int cyc       = 0;
    int last_rise = -1000;
    int fe_cnt    = 0;
    int ov_cnt    = 0;
    int long_cnt  = 0;
    logic valid_d = 1'b0;
    logic fe_d    = 1'b0;
    logic ov_d    = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rx_valid && !valid_d) last_rise = cyc;
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && fe_d) long_cnt++;
            if (overrun && ov_d) long_cnt++;
            valid_d = rx_valid;
            fe_d    = frame_err;
            ov_d    = overrun;
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    // Transmitter-style frame: start 0, data LSB first, stop; BAUD cycles per bit.
    // With ack_done, rx_ack is high exactly on the expected completion edge.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic ack_done,
                              output int t0);
        logic [9:0] f;
        f  = {stop, b, 1'b0};
        t0 = 0;
        for (int i = 0; i < 10 * BAUD; i++) begin
            @(negedge clk);
            if (i == 0) t0 = cyc;
            rx = f[i / BAUD];
            if (ack_done) rx_ack = (i == LAT - 1);
        end
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       ack_first;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_fe;
        int         exp_ov;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int t0;
        int fe0;
        int ov0;
        logic [7:0] rb;
        logic rstop;
        logic model_valid;
        logic [7:0] model_data;
        int exp_fe;
        int exp_ov;
        logic [7:0] got;
        logic [9:0] f;

        tbl[0] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 0, 0};
        tbl[1] = '{8'hA3, 1'b0, 1'b1, 8'hA3, 1'b0, 1, 0};
        tbl[2] = '{8'h0F, 1'b1, 1'b0, 8'h0F, 1'b1, 0, 0};
        tbl[3] = '{8'h12, 1'b1, 1'b0, 8'h12, 1'b1, 0, 1};
        tbl[4] = '{8'hE7, 1'b0, 1'b0, 8'hE7, 1'b1, 1, 0};
        tbl[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 0, 0};
        tbl[6] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 0, 0};

        rst_n  = 1'b0;
        rx     = 1'b1;
        rx_ack = 1'b0;
        #12;
        check("reset_data", data, 8'h00);
        check("reset_valid", rx_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_pulses", {frame_err, overrun}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(5);

        pulse_ack();
        check("ack_when_empty", rx_valid, 0);

        // Clean byte with latency and ack timing.
        send_frame(8'h55, 1'b1, 1'b0, t0);
        check_range("clean_latency", last_rise - t0, LAT - 1, LAT + 1);
        check("clean_data", data, 8'h55);
        check("clean_valid", rx_valid, 1);
        check("clean_fe", fe_cnt, 0);
        pulse_ack();
        check("clean_ack_clears", rx_valid, 0);
        idle(5);

        // Glitch shorter than half a bit.
        @(negedge clk);
        t0 = cyc;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(t0 + 6 - cyc);
        check("glitch_busy_high", busy, 1);
        idle(t0 + 12 - cyc);
        check("glitch_busy_dropped", busy, 0);
        check("glitch_valid", rx_valid, 0);
        check("glitch_data", data, 8'h55);
        idle(10);

        // Table of frames with hand-computed results.
        for (int k = 0; k < 7; k++) begin
            if (tbl[k].ack_first) pulse_ack();
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            send_frame(tbl[k].b, tbl[k].stop, 1'b0, t0);
            if (!tbl[k].stop) begin
                idle(40);
                check($sformatf("tbl%0d_busy_low_line", k), busy, 1);
                rx = 1'b1;
                idle(6);
                check($sformatf("tbl%0d_busy_released", k), busy, 0);
            end
            idle(4);
            check($sformatf("tbl%0d_data", k), data, tbl[k].exp_data);
            check($sformatf("tbl%0d_valid", k), rx_valid, tbl[k].exp_valid);
            check($sformatf("tbl%0d_fe", k), fe_cnt - fe0, tbl[k].exp_fe);
            check($sformatf("tbl%0d_ov", k), ov_cnt - ov0, tbl[k].exp_ov);
        end

        // Back-to-back without ack: second completion overruns.
        pulse_ack();
        ov0 = ov_cnt;
        send_frame(8'h12, 1'b1, 1'b0, t0);
        check("b2b_first_ov", ov_cnt - ov0, 0);
        send_frame(8'h34, 1'b1, 1'b0, t0);
        check("b2b_data", data, 8'h34);
        check("b2b_valid", rx_valid, 1);
        check("b2b_ov", ov_cnt - ov0, 1);
        idle(5);

        // Back-to-back with ack on the completion edge: no overrun.
        pulse_ack();
        ov0 = ov_cnt;
        send_frame(8'h12, 1'b1, 1'b0, t0);
        send_frame(8'h34, 1'b1, 1'b1, t0);
        rx_ack = 1'b0;
        check("b2b_ack_data", data, 8'h34);
        check("b2b_ack_valid", rx_valid, 1);
        check("b2b_ack_ov", ov_cnt - ov0, 0);
        idle(5);

        // Asynchronous reset during data bit 4 of 0xFF.
        f = {1'b1, 8'hFF, 1'b0};
        for (int i = 0; i < 5 * BAUD + 8; i++) begin
            @(negedge clk);
            rx = f[i / BAUD];
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_valid", rx_valid, 0);
        check("midrst_busy", busy, 0);
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(5);
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'h81, 1'b1, 1'b0, t0);
        idle(3);
        check("postrst_data", data, 8'h81);
        check("postrst_valid", rx_valid, 1);
        check("postrst_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
        pulse_ack();

        // Randomized frames against a frame-level model.
        model_valid = 1'b0;
        model_data  = 8'h81;
        for (int k = 0; k < 16; k++) begin
            rb    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                model_valid = 1'b0;
            end
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            exp_fe = 0;
            exp_ov = 0;
            if (rstop) begin
                exp_ov      = model_valid ? 1 : 0;
                model_valid = 1'b1;
            end else begin
                exp_fe = 1;
            end
            model_data = rb;
            send_frame(rb, rstop, 1'b0, t0);
            if (!rstop) begin
                idle(20);
                rx = 1'b1;
            end
            idle($urandom_range(6, 20));
            check($sformatf("rnd%0d_data", k), data, model_data);
            check($sformatf("rnd%0d_valid", k), rx_valid, model_valid);
            check($sformatf("rnd%0d_fe", k), fe_cnt - fe0, exp_fe);
            check($sformatf("rnd%0d_ov", k), ov_cnt - ov0, exp_ov);
        end

        // Loopback stream from the transmitter model, consumer acks each byte.
        pulse_ack();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: rb = 8'h00;
                1: rb = 8'hFF;
                2: rb = 8'h5A;
                3: rb = 8'hC3;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            exp_q.push_back(rb);
            send_frame(rb, 1'b1, 1'b0, t0);
            check($sformatf("loop%0d_valid", k), rx_valid, 1);
            got = exp_q.pop_front();
            check($sformatf("loop%0d_data", k), data, got);
            pulse_ack();
        end
        check("loop_fe", fe_cnt - fe0, 0);
        check("loop_ov", ov_cnt - ov0, 0);
        check("loop_queue_empty", exp_q.size(), 0);

        check("single_cycle_pulses", long_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
